// File: rtl/qnigma_pkg.sv
// Shared types and helpers for the qnigma TCP blocks: fast-recovery state
// encoding and modular sequence-number comparison.
package qnigma_pkg;

   typedef enum logic [1:0] {
      FR_IDLE     = 2'd0,
      FR_COUNT    = 2'd1,
      FR_RECOVERY = 2'd2
   } fr_state_t;

   // a is after b when (a-b), taken as a signed w-bit value, is positive
   function automatic logic seq_after(input logic [63:0] a, input logic [63:0] b, input int w);
      logic [63:0] d;
      d = (a - b) << (64 - w);
      return (d[63] == 1'b0) && (d != 64'd0);
   endfunction

endpackage

// File: rtl/qnigma_tcp_fast_recovery.sv
// TCP duplicate-ACK tracking with fast retransmit and NewReno-style fast
// recovery (partial ACKs retransmit, full ACK exits).
module qnigma_tcp_fast_recovery
   import qnigma_pkg::*;
#(
   parameter int ACK_W   = 32,
   parameter int DUP_THR = 3,
   parameter int CNT_W   = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             connected,
   input  logic             val,
   input  logic             ack_flg,
   input  logic [ACK_W-1:0] ack,
   input  logic             has_pld,
   input  logic             wnd_chg,
   input  logic [ACK_W-1:0] snd_nxt,
   output logic             rtx_req,
   output logic [ACK_W-1:0] rtx_seq,
   output logic             in_rec,
   output logic [ACK_W-1:0] rec_point,
   output logic             inflate,
   output logic             rec_exit,
   output logic [CNT_W-1:0] dup_cnt
);

   localparam logic [CNT_W-1:0] THR = CNT_W'(DUP_THR);

   fr_state_t        state_r, state_s;
   logic [ACK_W-1:0] snd_una_r, snd_una_s;
   logic [ACK_W-1:0] rtx_seq_r, rtx_seq_s;
   logic [ACK_W-1:0] rec_point_r, rec_point_s;
   logic [CNT_W-1:0] dup_cnt_r, dup_cnt_s, cnt_inc_s;
   logic             rtx_req_r, rtx_req_s;
   logic             inflate_r, inflate_s;
   logic             rec_exit_r, rec_exit_s;
   logic             strobe_s, dup_s, new_s;

   assign strobe_s  = val & ack_flg & connected;
   assign dup_s     = strobe_s & (ack == snd_una_r) & ~has_pld & ~wnd_chg & (snd_nxt != snd_una_r);
   assign new_s     = strobe_s & seq_after(64'(ack), 64'(snd_una_r), ACK_W)
                               & ~seq_after(64'(ack), 64'(snd_nxt), ACK_W);
   assign cnt_inc_s = (dup_cnt_r == {CNT_W{1'b1}}) ? dup_cnt_r : dup_cnt_r + 1'b1;

   // next-state and next-output decode
   always_comb begin
      state_s     = state_r;
      snd_una_s   = snd_una_r;
      rtx_seq_s   = rtx_seq_r;
      rec_point_s = rec_point_r;
      dup_cnt_s   = dup_cnt_r;
      rtx_req_s   = 1'b0;
      inflate_s   = 1'b0;
      rec_exit_s  = 1'b0;
      if (!connected) begin
         // dropping the connection resynchronises snd_una to the send pointer
         state_s   = FR_IDLE;
         dup_cnt_s = {CNT_W{1'b0}};
         snd_una_s = snd_nxt;
      end else begin
         if (new_s) snd_una_s = ack;
         else       snd_una_s = snd_una_r;
         case (state_r)
            FR_IDLE, FR_COUNT: begin
               if (dup_s) begin
                  dup_cnt_s = cnt_inc_s;
                  if (cnt_inc_s >= THR) begin
                     state_s     = FR_RECOVERY;
                     rtx_req_s   = 1'b1;
                     rtx_seq_s   = snd_una_r;
                     rec_point_s = snd_nxt;
                  end else begin
                     state_s = FR_COUNT;
                  end
               end else if (new_s) begin
                  state_s   = FR_IDLE;
                  dup_cnt_s = {CNT_W{1'b0}};
               end else begin
                  state_s = state_r;
               end
            end
            FR_RECOVERY: begin
               if (dup_s) begin
                  inflate_s = 1'b1;
                  dup_cnt_s = cnt_inc_s;
               end else if (new_s) begin
                  dup_cnt_s = {CNT_W{1'b0}};
                  // ack at or beyond rec_point is a full ACK
                  if (!seq_after(64'(rec_point_r), 64'(ack), ACK_W)) begin
                     state_s    = FR_IDLE;
                     rec_exit_s = 1'b1;
                  end else begin
                     rtx_req_s = 1'b1;
                     rtx_seq_s = ack;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            default: begin
               state_s   = FR_IDLE;
               dup_cnt_s = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= FR_IDLE;
         snd_una_r   <= {ACK_W{1'b0}};
         rtx_seq_r   <= {ACK_W{1'b0}};
         rec_point_r <= {ACK_W{1'b0}};
         dup_cnt_r   <= {CNT_W{1'b0}};
         rtx_req_r   <= 1'b0;
         inflate_r   <= 1'b0;
         rec_exit_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         snd_una_r   <= snd_una_s;
         rtx_seq_r   <= rtx_seq_s;
         rec_point_r <= rec_point_s;
         dup_cnt_r   <= dup_cnt_s;
         rtx_req_r   <= rtx_req_s;
         inflate_r   <= inflate_s;
         rec_exit_r  <= rec_exit_s;
      end
   end

   assign rtx_req   = rtx_req_r;
   assign rtx_seq   = rtx_seq_r;
   assign in_rec    = (state_r == FR_RECOVERY);
   assign rec_point = rec_point_r;
   assign inflate   = inflate_r;
   assign rec_exit  = rec_exit_r;
   assign dup_cnt   = dup_cnt_r;

endmodule

// File: tb/tb_qnigma_tcp_fast_recovery.sv
// Scoreboard bench for qnigma_tcp_fast_recovery: each vector pushes its
// expected registered outputs, which are popped and checked after the edge.
module tb_qnigma_tcp_fast_recovery;

   localparam int ACK_W = 32;
   localparam int CNT_W = 8;

   typedef struct {
      logic             rtx_req;
      logic [ACK_W-1:0] rtx_seq;
      logic             in_rec;
      logic [ACK_W-1:0] rec_point;
      logic             inflate;
      logic             rec_exit;
      logic [CNT_W-1:0] dup_cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             connected = 1'b0;
   logic             val = 1'b0;
   logic             ack_flg = 1'b0;
   logic [ACK_W-1:0] ack = 32'd0;
   logic             has_pld = 1'b0;
   logic             wnd_chg = 1'b0;
   logic [ACK_W-1:0] snd_nxt = 32'd0;
   logic             rtx_req, in_rec, inflate, rec_exit;
   logic [ACK_W-1:0] rtx_seq, rec_point;
   logic [CNT_W-1:0] dup_cnt;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   qnigma_tcp_fast_recovery #(.ACK_W(ACK_W), .DUP_THR(3), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .connected(connected), .val(val), .ack_flg(ack_flg),
      .ack(ack), .has_pld(has_pld), .wnd_chg(wnd_chg), .snd_nxt(snd_nxt),
      .rtx_req(rtx_req), .rtx_seq(rtx_seq), .in_rec(in_rec), .rec_point(rec_point),
      .inflate(inflate), .rec_exit(rec_exit), .dup_cnt(dup_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".rtx_req"},   64'(rtx_req),   64'(e.rtx_req));
      chk({tag, ".rtx_seq"},   64'(rtx_seq),   64'(e.rtx_seq));
      chk({tag, ".in_rec"},    64'(in_rec),    64'(e.in_rec));
      chk({tag, ".rec_point"}, 64'(rec_point), 64'(e.rec_point));
      chk({tag, ".inflate"},   64'(inflate),   64'(e.inflate));
      chk({tag, ".rec_exit"},  64'(rec_exit),  64'(e.rec_exit));
      chk({tag, ".dup_cnt"},   64'(dup_cnt),   64'(e.dup_cnt));
   endtask

   function automatic exp_t mk(input logic rq, input logic [31:0] rs, input logic ir,
                               input logic [31:0] rp, input logic inf, input logic rx,
                               input logic [7:0] dc);
      exp_t e;
      e.rtx_req = rq; e.rtx_seq = rs; e.in_rec = ir; e.rec_point = rp;
      e.inflate = inf; e.rec_exit = rx; e.dup_cnt = dc;
      return e;
   endfunction

   // drive one cycle of inputs, queue the expectation, compare after the edge
   task automatic vec(input string tag, input logic v, input logic af, input logic [31:0] a,
                      input logic hp, input logic wc, input exp_t e);
      exp_t got;
      @(negedge clk);
      val = v; ack_flg = af; ack = a; has_pld = hp; wnd_chg = wc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      val = 1'b0; has_pld = 1'b0; wnd_chg = 1'b0;
      if (exp_q.size() == 0) begin
         chk({tag, ".queue"}, 64'd0, 64'd1);
      end else begin
         got = exp_q.pop_front();
         chk_all(tag, got);
      end
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0));
      @(negedge clk);
      rst = 1'b0;

      // load snd_una = 1000 through a disconnected cycle
      snd_nxt = 32'd1000;
      vec("disc", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0));
      @(negedge clk);
      connected = 1'b1;
      snd_nxt   = 32'd5000;

      vec("dup1", 1'b1, 1'b1, 32'd1000, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd1));
      vec("dup2", 1'b1, 1'b1, 32'd1000, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd2));
      vec("dup3", 1'b1, 1'b1, 32'd1000, 1'b0, 1'b0, mk(1'b1, 32'd1000, 1'b1, 32'd5000, 1'b0, 1'b0, 8'd3));
      vec("dup4", 1'b1, 1'b1, 32'd1000, 1'b0, 1'b0, mk(1'b0, 32'd1000, 1'b1, 32'd5000, 1'b1, 1'b0, 8'd4));
      vec("dup5", 1'b1, 1'b1, 32'd1000, 1'b0, 1'b0, mk(1'b0, 32'd1000, 1'b1, 32'd5000, 1'b1, 1'b0, 8'd5));
      vec("hold", 1'b0, 1'b1, 32'd1000, 1'b0, 1'b0, mk(1'b0, 32'd1000, 1'b1, 32'd5000, 1'b0, 1'b0, 8'd5));
      vec("part", 1'b1, 1'b1, 32'd3000, 1'b0, 1'b0, mk(1'b1, 32'd3000, 1'b1, 32'd5000, 1'b0, 1'b0, 8'd0));
      vec("full", 1'b1, 1'b1, 32'd5000, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b1, 8'd0));
      // snd_una now equals snd_nxt: nothing outstanding, so not a duplicate
      vec("nooutst", 1'b1, 1'b1, 32'd5000, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd0));

      // wrap-around: snd_una = 0xFFFFFF00, snd_nxt = 0x100
      @(negedge clk);
      connected = 1'b0;
      snd_nxt   = 32'hFFFF_FF00;
      vec("disc2", 1'b1, 1'b1, 32'd5000, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd0));
      @(negedge clk);
      connected = 1'b1;
      snd_nxt   = 32'h0000_0100;
      vec("wrapnew", 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd0));
      vec("wrapdup", 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd1));
      vec("pld",     1'b1, 1'b1, 32'h10, 1'b1, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd1));
      vec("wnd",     1'b1, 1'b1, 32'h10, 1'b0, 1'b1, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd1));
      vec("dup2b",   1'b1, 1'b1, 32'h10, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd2));
      vec("noackf",  1'b1, 1'b0, 32'h10, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd2));
      vec("beyond",  1'b1, 1'b1, 32'h200, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd2));
      vec("newidle", 1'b1, 1'b1, 32'h50, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd0));
      vec("old",     1'b1, 1'b1, 32'h10, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd0));

      // enter recovery again, then reset between edges
      vec("r1", 1'b1, 1'b1, 32'h50, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd1));
      vec("r2", 1'b1, 1'b1, 32'h50, 1'b0, 1'b0, mk(1'b0, 32'd3000, 1'b0, 32'd5000, 1'b0, 1'b0, 8'd2));
      vec("r3", 1'b1, 1'b1, 32'h50, 1'b0, 1'b0, mk(1'b1, 32'h50, 1'b1, 32'h100, 1'b0, 1'b0, 8'd3));
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_all("rstasync", mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0));
      @(negedge clk);
      rst = 1'b0;
      vec("postrst", 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0));
      vec("postrst2", 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0));

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/qnigma_tcp_fast_recovery.md
QNIGMA_TCP_FAST_RECOVERY -- requirements
Module: qnigma_tcp_fast_recovery

Interface
REQ-001 SHALL have parameter ACK_W, default 32, sequence/ack width in bits.
REQ-002 SHALL have parameter DUP_THR, default 3, duplicate-ACK count that triggers fast retransmit (legal range 1..15).
REQ-003 SHALL have parameter CNT_W, default 8, width of the saturating duplicate counter.
REQ-004 SHALL have ports:
  clk        in   1      clock; all logic on rising edge
  rst        in   1      reset, asynchronous, active-high
  connected  in   1      connection in established state; 0 forces IDLE
  val        in   1      one-cycle strobe: received segment fields valid
  ack_flg    in   1      ACK flag of received segment
  ack        in   ACK_W  acknowledgment number of received segment
  has_pld    in   1      received segment carries payload
  wnd_chg    in   1      advertised window differs from previous
  snd_nxt    in   ACK_W  next sequence number to be sent
  rtx_req    out  1      one-cycle pulse: retransmit segment at rtx_seq
  rtx_seq    out  ACK_W  sequence number to retransmit
  in_rec     out  1      fast-recovery active
  rec_point  out  ACK_W  snd_nxt captured on recovery entry
  inflate    out  1      one-cycle pulse: extra dup ACK in recovery (cwnd += MSS)
  rec_exit   out  1      one-cycle pulse: full ACK ended recovery
  dup_cnt    out  CNT_W  current duplicate count, saturating at 2^CNT_W-1

Function
REQ-005 SHALL keep internal snd_una register (ACK_W) holding the highest cumulative ack accepted.
REQ-006 SHALL compare sequence numbers modulo 2^ACK_W: a after b iff (a-b) as signed ACK_W is > 0.
REQ-007 SHALL classify a strobe (val & ack_flg & connected) as duplicate iff ack == snd_una, !has_pld, !wnd_chg and snd_nxt != snd_una.
REQ-008 SHALL classify as new ACK iff ack after snd_una and ack not after snd_nxt; new ACK SHALL set snd_una <= ack.
REQ-009 SHALL ignore (no state/counter change) acks before snd_una or after snd_nxt.
REQ-010 SHALL implement states IDLE, COUNT, RECOVERY; all outputs registered, one cycle after val.
REQ-011 IDLE: duplicate -> COUNT, dup_cnt=1; if DUP_THR==1, act as REQ-012 on same strobe instead.
REQ-012 COUNT: duplicate increments dup_cnt; reaching DUP_THR -> RECOVERY, rtx_req pulse, rtx_seq=snd_una, rec_point=snd_nxt, in_rec=1.
REQ-013 COUNT: new ACK -> IDLE, dup_cnt=0.
REQ-014 RECOVERY: duplicate -> inflate pulse, dup_cnt increments saturating; no rtx_req.
REQ-015 RECOVERY: new ACK with ack after-or-equal rec_point (full ACK) -> IDLE, rec_exit pulse, in_rec=0, dup_cnt=0.
REQ-016 RECOVERY: new ACK before rec_point (partial ACK) -> stay, rtx_req pulse, rtx_seq=ack, dup_cnt=0.
REQ-017 connected=0 SHALL force IDLE, in_rec=0, dup_cnt=0, suppress all pulses next cycle; snd_una SHALL load snd_nxt.
REQ-018 val asserted with connected=1 but ack_flg=0 SHALL have no effect.
REQ-019 rtx_req, inflate, rec_exit SHALL be mutually exclusive and never exceed one cycle.
REQ-020 rtx_seq and rec_point SHALL hold value until next update.

Reset
REQ-021 On rst: state IDLE, snd_una=0, dup_cnt=0, rtx_seq=0, rec_point=0, in_rec=0, rtx_req=0, inflate=0, rec_exit=0.
REQ-022 rst mid-recovery SHALL abort immediately with no rec_exit pulse.

Structure
REQ-023 Sequence compare function (seq_after) and state enum fr_state_t SHALL live in qnigma_pkg.
REQ-024 SHALL be flat; no sub-module.

Verification
REQ-025 snd_una=1000, snd_nxt=5000, three dup ACKs ack=1000 -> rtx_req once on third, rtx_seq=1000, rec_point=5000, in_rec=1.
REQ-026 In recovery, two more dup ACKs -> two inflate pulses, dup_cnt=5, no rtx_req.
REQ-027 In recovery, ack=3000 -> rtx_req, rtx_seq=3000; then ack=5000 -> rec_exit, in_rec=0, dup_cnt=0.
REQ-028 snd_una=0xFFFFFF00, snd_nxt=0x00000100, ack=0x00000010 -> accepted as new ACK (wrap-around).
REQ-029 Dup ACK with has_pld=1 or wnd_chg=1 -> dup_cnt unchanged; two dups then new ACK -> IDLE, no rtx_req.
REQ-030 rst asserted between clock edges during RECOVERY -> all outputs 0 immediately, no rec_exit.
